// File: rtl/hdmi_packet_scheduler.sv
// Data-island packet arbiter for the HDMI transmitter: picks ACR, audio sample,
// InfoFrame or null packet for each packet slot, with an audio run limit so InfoFrames are not starved.
module hdmi_packet_scheduler #(
    parameter int MAX_AUDIO_RUN = 4,
    parameter int SPD_ENABLE    = 1,
    parameter int OVF_WIDTH     = 8
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic                 packet_enable,
    input  logic                 acr_wrap,
    input  logic                 audio_pending,
    input  logic                 frame_start,
    output logic                 audio_ack,
    output logic [2:0]           packet_select,
    output logic [7:0]           packet_type,
    output logic [OVF_WIDTH-1:0] acr_overrun
);

    localparam int RUN_W = (MAX_AUDIO_RUN < 1) ? 1 : $clog2(MAX_AUDIO_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_AUDIO_RUN);
    localparam logic [OVF_WIDTH-1:0] OVF_MAX = {OVF_WIDTH{1'b1}};

    localparam logic [2:0] SEL_NULL  = 3'd0;
    localparam logic [2:0] SEL_ACR   = 3'd1;
    localparam logic [2:0] SEL_AUDIO = 3'd2;
    localparam logic [2:0] SEL_AVI   = 3'd3;
    localparam logic [2:0] SEL_AIF   = 3'd4;
    localparam logic [2:0] SEL_SPD   = 3'd5;

    // HB0 header byte for each packet source
    function automatic logic [7:0] hb0_of(input logic [2:0] sel);
        logic [7:0] hb;
        case (sel)
            SEL_NULL:  hb = 8'h00;
            SEL_ACR:   hb = 8'h01;
            SEL_AUDIO: hb = 8'h02;
            SEL_AVI:   hb = 8'h82;
            SEL_AIF:   hb = 8'h84;
            SEL_SPD:   hb = 8'h83;
            default:   hb = 8'h00;
        endcase
        return hb;
    endfunction

    logic                 acr_wrap_q, acr_wrap_d;
    logic                 acr_pend_q, acr_pend_d;
    logic                 avi_pend_q, avi_pend_d;
    logic                 aif_pend_q, aif_pend_d;
    logic                 spd_pend_q, spd_pend_d;
    logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
    logic [OVF_WIDTH-1:0] acr_overrun_q, acr_overrun_d;
    logic [2:0]           packet_select_q, packet_select_d;
    logic [7:0]           packet_type_q, packet_type_d;
    logic                 audio_ack_q, audio_ack_d;

    logic       acr_edge;
    logic       if_pend;
    logic       skip_audio;
    logic [2:0] winner;
    logic [2:0] grant;
    logic       spd_set;

    // Arbitration on the registered flags, then flag/counter updates
    always_comb begin
        acr_edge   = acr_wrap ^ acr_wrap_q;
        if_pend    = avi_pend_q | aif_pend_q | spd_pend_q;
        skip_audio = if_pend && (run_cnt_q == RUN_MAX);
        spd_set    = (SPD_ENABLE != 0) ? frame_start : 1'b0;

        if (acr_pend_q) begin
            winner = SEL_ACR;
        end else if (audio_pending && !skip_audio) begin
            winner = SEL_AUDIO;
        end else if (avi_pend_q) begin
            winner = SEL_AVI;
        end else if (aif_pend_q) begin
            winner = SEL_AIF;
        end else if (spd_pend_q) begin
            winner = SEL_SPD;
        end else begin
            winner = SEL_NULL;
        end

        grant = packet_enable ? winner : SEL_NULL;

        acr_wrap_d    = acr_wrap;
        acr_overrun_d = acr_overrun_q;
        if (acr_edge) begin
            // A new CTS landing on the ACR grant simply re-arms the flag
            acr_pend_d = 1'b1;
            if (acr_pend_q && (grant != SEL_ACR) && (acr_overrun_q != OVF_MAX)) begin
                acr_overrun_d = acr_overrun_q + {{(OVF_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                acr_overrun_d = acr_overrun_q;
            end
        end else if (grant == SEL_ACR) begin
            acr_pend_d = 1'b0;
        end else begin
            acr_pend_d = acr_pend_q;
        end

        avi_pend_d = frame_start | (avi_pend_q & (grant != SEL_AVI));
        aif_pend_d = frame_start | (aif_pend_q & (grant != SEL_AIF));
        spd_pend_d = spd_set     | (spd_pend_q & (grant != SEL_SPD));

        if (!if_pend) begin
            run_cnt_d = {RUN_W{1'b0}};
        end else if ((grant == SEL_AVI) || (grant == SEL_AIF) || (grant == SEL_SPD)) begin
            run_cnt_d = {RUN_W{1'b0}};
        end else if ((grant == SEL_AUDIO) && (run_cnt_q != {RUN_W{1'b1}})) begin
            run_cnt_d = run_cnt_q + {{(RUN_W-1){1'b0}}, 1'b1};
        end else begin
            run_cnt_d = run_cnt_q;
        end

        if (packet_enable) begin
            packet_select_d = winner;
            packet_type_d   = hb0_of(winner);
        end else begin
            packet_select_d = packet_select_q;
            packet_type_d   = packet_type_q;
        end

        audio_ack_d = (grant == SEL_AUDIO);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            acr_wrap_q      <= 1'b0;
            acr_pend_q      <= 1'b0;
            avi_pend_q      <= 1'b0;
            aif_pend_q      <= 1'b0;
            spd_pend_q      <= 1'b0;
            run_cnt_q       <= {RUN_W{1'b0}};
            acr_overrun_q   <= {OVF_WIDTH{1'b0}};
            packet_select_q <= SEL_NULL;
            packet_type_q   <= 8'h00;
            audio_ack_q     <= 1'b0;
        end else begin
            acr_wrap_q      <= acr_wrap_d;
            acr_pend_q      <= acr_pend_d;
            avi_pend_q      <= avi_pend_d;
            aif_pend_q      <= aif_pend_d;
            spd_pend_q      <= spd_pend_d;
            run_cnt_q       <= run_cnt_d;
            acr_overrun_q   <= acr_overrun_d;
            packet_select_q <= packet_select_d;
            packet_type_q   <= packet_type_d;
            audio_ack_q     <= audio_ack_d;
        end
    end

    assign audio_ack     = audio_ack_q;
    assign packet_select = packet_select_q;
    assign packet_type   = packet_type_q;
    assign acr_overrun   = acr_overrun_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler; a second instance with SPD disabled
// shares the stimulus for the SPD_ENABLE=0 case.
module tb_hdmi_packet_scheduler;

    logic       clk_pixel = 1'b0;
    logic       reset_n = 1'b0;
    logic       packet_enable = 1'b0;
    logic       acr_wrap = 1'b0;
    logic       audio_pending = 1'b0;
    logic       frame_start = 1'b0;
    logic       audio_ack, audio_ack_n;
    logic [2:0] packet_select, packet_select_n;
    logic [7:0] packet_type, packet_type_n;
    logic [7:0] acr_overrun, acr_overrun_n;

    int checks = 0;
    int failures = 0;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_packet_scheduler #(.MAX_AUDIO_RUN(4), .SPD_ENABLE(1), .OVF_WIDTH(8)) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_enable(packet_enable),
        .acr_wrap(acr_wrap), .audio_pending(audio_pending), .frame_start(frame_start),
        .audio_ack(audio_ack), .packet_select(packet_select),
        .packet_type(packet_type), .acr_overrun(acr_overrun));

    hdmi_packet_scheduler #(.MAX_AUDIO_RUN(4), .SPD_ENABLE(0), .OVF_WIDTH(8)) dut_nospd (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_enable(packet_enable),
        .acr_wrap(acr_wrap), .audio_pending(audio_pending), .frame_start(frame_start),
        .audio_ack(audio_ack_n), .packet_select(packet_select_n),
        .packet_type(packet_type_n), .acr_overrun(acr_overrun_n));

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_slot();
        packet_enable = 1'b1;
        tick();
        packet_enable = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        packet_enable = 1'b0;
        acr_wrap = 1'b0;
        audio_pending = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 4;
        if (packet_select !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", packet_select); end
        if (packet_type !== 8'h00) begin failures++; $display("FAIL reset_type got=%h exp=00", packet_type); end
        if (audio_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", audio_ack); end
        if (acr_overrun !== 8'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", acr_overrun); end
        do_slot();
        checks += 3;
        if (packet_select !== 3'd0) begin failures++; $display("FAIL idle_sel got=%0d exp=0", packet_select); end
        if (packet_type !== 8'h00) begin failures++; $display("FAIL idle_type got=%h exp=00", packet_type); end
        if (audio_ack !== 1'b0) begin failures++; $display("FAIL idle_ack got=%b exp=0", audio_ack); end
    endtask

    task automatic test_acr_audio();
        apply_reset();
        acr_wrap = 1'b1;
        tick();
        audio_pending = 1'b1;
        do_slot();
        checks += 3;
        if (packet_select !== 3'd1) begin failures++; $display("FAIL acr_sel got=%0d exp=1", packet_select); end
        if (packet_type !== 8'h01) begin failures++; $display("FAIL acr_type got=%h exp=01", packet_type); end
        if (audio_ack !== 1'b0) begin failures++; $display("FAIL acr_ack got=%b exp=0", audio_ack); end
        do_slot();
        checks += 3;
        if (packet_select !== 3'd2) begin failures++; $display("FAIL aud_sel got=%0d exp=2", packet_select); end
        if (packet_type !== 8'h02) begin failures++; $display("FAIL aud_type got=%h exp=02", packet_type); end
        if (audio_ack !== 1'b1) begin failures++; $display("FAIL aud_ack got=%b exp=1", audio_ack); end
        tick();
        checks += 2;
        if (audio_ack !== 1'b0) begin failures++; $display("FAIL aud_ack_drop got=%b exp=0", audio_ack); end
        if (packet_type !== 8'h02) begin failures++; $display("FAIL aud_hold got=%h exp=02", packet_type); end
        audio_pending = 1'b0;
    endtask

    task automatic test_run_limit();
        logic [7:0] exp_t [10] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h82,
                                   8'h02, 8'h02, 8'h84, 8'h83, 8'h00};
        apply_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            audio_pending = (i < 7) ? 1'b1 : 1'b0;
            do_slot();
            checks += 2;
            if (packet_type !== exp_t[i]) begin
                failures++;
                $display("FAIL run_type slot=%0d got=%h exp=%h", i, packet_type, exp_t[i]);
            end
            if (audio_ack !== (exp_t[i] == 8'h02)) begin
                failures++;
                $display("FAIL run_ack slot=%0d got=%b exp=%b", i, audio_ack, exp_t[i] == 8'h02);
            end
        end
    endtask

    task automatic test_no_spd();
        logic [7:0] exp_spd [3] = '{8'h82, 8'h84, 8'h83};
        logic [7:0] exp_nos [3] = '{8'h82, 8'h84, 8'h00};
        apply_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_slot();
            checks += 2;
            if (packet_type_n !== exp_nos[i]) begin
                failures++;
                $display("FAIL nospd_type slot=%0d got=%h exp=%h", i, packet_type_n, exp_nos[i]);
            end
            if (packet_type !== exp_spd[i]) begin
                failures++;
                $display("FAIL spd_type slot=%0d got=%h exp=%h", i, packet_type, exp_spd[i]);
            end
        end
    endtask

    task automatic test_acr_overrun();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            acr_wrap = ~acr_wrap;
            tick();
        end
        checks += 1;
        if (acr_overrun !== 8'd2) begin failures++; $display("FAIL ovf_count got=%0d exp=2", acr_overrun); end
        do_slot();
        checks += 2;
        if (packet_type !== 8'h01) begin failures++; $display("FAIL ovf_grant got=%h exp=01", packet_type); end
        if (acr_overrun !== 8'd2) begin failures++; $display("FAIL ovf_keep got=%0d exp=2", acr_overrun); end
        do_slot();
        checks += 1;
        if (packet_type !== 8'h00) begin failures++; $display("FAIL ovf_cleared got=%h exp=00", packet_type); end
        acr_wrap = ~acr_wrap;
        tick();
        acr_wrap = ~acr_wrap;
        do_slot();
        checks += 2;
        if (packet_type !== 8'h01) begin failures++; $display("FAIL coinc_grant got=%h exp=01", packet_type); end
        if (acr_overrun !== 8'd2) begin failures++; $display("FAIL coinc_ovf got=%0d exp=2", acr_overrun); end
        do_slot();
        checks += 1;
        if (packet_type !== 8'h01) begin failures++; $display("FAIL coinc_repend got=%h exp=01", packet_type); end
        do_slot();
        checks += 1;
        if (packet_type !== 8'h00) begin failures++; $display("FAIL coinc_done got=%h exp=00", packet_type); end
    endtask

    task automatic test_overrun_saturation();
        apply_reset();
        for (int i = 0; i < 258; i++) begin
            acr_wrap = ~acr_wrap;
            tick();
        end
        checks += 1;
        if (acr_overrun !== 8'hFF) begin failures++; $display("FAIL ovf_sat got=%0d exp=255", acr_overrun); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        acr_wrap = 1'b1;
        frame_start = 1'b1;
        packet_enable = 1'b1;
        tick();
        packet_enable = 1'b0;
        frame_start = 1'b0;
        checks += 1;
        if (packet_type !== 8'h00) begin failures++; $display("FAIL same_null got=%h exp=00", packet_type); end
        do_slot();
        checks += 1;
        if (packet_type !== 8'h01) begin failures++; $display("FAIL same_acr got=%h exp=01", packet_type); end
        do_slot();
        checks += 1;
        if (packet_type !== 8'h82) begin failures++; $display("FAIL same_avi got=%h exp=82", packet_type); end
    endtask

    task automatic test_reset_mid_slot();
        apply_reset();
        audio_pending = 1'b1;
        do_slot();
        acr_wrap = 1'b1;
        frame_start = 1'b1;
        packet_enable = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        packet_enable = 1'b0;
        frame_start = 1'b0;
        audio_pending = 1'b0;
        checks += 2;
        if (packet_type !== 8'h00) begin failures++; $display("FAIL midrst_type got=%h exp=00", packet_type); end
        if (audio_ack !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b exp=0", audio_ack); end
        acr_wrap = 1'b0;
        tick();
        acr_wrap = 1'b1;
        tick();
        do_slot();
        checks += 1;
        if (packet_type !== 8'h01) begin failures++; $display("FAIL midrst_acr got=%h exp=01", packet_type); end
        do_slot();
        checks += 1;
        if (packet_type !== 8'h00) begin failures++; $display("FAIL midrst_lost got=%h exp=00", packet_type); end
    endtask

    initial begin
        test_reset();
        test_acr_audio();
        test_run_limit();
        test_no_spd();
        test_acr_overrun();
        test_overrun_saturation();
        test_same_cycle();
        test_reset_mid_slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
